// File: rtl/dmem_requester_if.sv
// dmem_requester_if: bundle of pipeline-side request/response signals and
// memory-side strobes for the data-memory requester.
//   master : view used by the requester (drives ready/stall/resp/err and the
//            memory strobes, address and write data; samples requests and
//            memory read data).
//   slave  : view used by the environment (pipeline + memory) that drives the
//            requests and mem_rdata_i.
// Signal names keep the _i/_o suffixes of the requester's port list so they
// read the same from both sides.
interface dmem_requester_if;
  logic        req_valid_i;
  logic        req_write_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        req_ready_o;
  logic        stall_o;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        err_o;
  logic        mem_write_o;
  logic        mem_read_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  modport master (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, mem_rdata_i,
    output req_ready_o, stall_o, resp_valid_o, resp_rdata_o, err_o,
           mem_write_o, mem_read_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, mem_rdata_i,
    input  req_ready_o, stall_o, resp_valid_o, resp_rdata_o, err_o,
           mem_write_o, mem_read_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dmem_requester.sv
// dmem_requester: load/store initiator for the CPU MEM stage.
// Accepts one request per handshake, drives the memory strobes for one cycle
// (store) or MEM_LATENCY cycles (load), returns load data with a one-cycle
// resp_valid_o pulse and raises stall_o while a request waits on a busy unit.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-low reset
//   bus    : dmem_requester_if.master (pipeline request/response + memory side)
// Parameters:
//   MEM_LATENCY : cycles mem_read_o is held before mem_rdata_i is sampled (1..15)
//   ADDR_WORDS  : words in the attached memory (range check)
// Optional build macro:
//   MISALIGN_TRAP_EN : misaligned or out-of-range requests complete with err_o
//                      and never strobe memory; when undefined err_o is 0 and
//                      addr[1:0] is ignored.
module dmem_requester #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned ADDR_WORDS  = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  dmem_requester_if.master   bus
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITE     = 2'd1;
  localparam logic [1:0] READ_WAIT = 2'd2;
  localparam logic [1:0] RESP      = 2'd3;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] word_idx;

  assign word_idx = {2'b00, bus.req_addr_i[31:2]};

`ifdef MISALIGN_TRAP_EN
  logic bad_req;
  logic err_q;
  assign bad_req = (bus.req_addr_i[1:0] != 2'b00) || (word_idx >= ADDR_WORDS);
`else
  // Byte offset and memory size only matter to the trap logic.
  logic [1:0] addr_lsb_unused;
  assign addr_lsb_unused = bus.req_addr_i[1:0];
  localparam int unsigned addr_words_unused = ADDR_WORDS;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
`ifdef MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            addr_q  <= word_idx;
            wdata_q <= bus.req_wdata_i;
`ifdef MISALIGN_TRAP_EN
            err_q   <= 1'b0;
            // Trapped requests skip memory entirely and report in RESP.
            if (bad_req) begin
              state <= RESP;
              err_q <= 1'b1;
            end else
`endif
            if (bus.req_write_i) begin
              state <= WRITE;
            end else begin
              state <= READ_WAIT;
              cnt   <= LAT_LOAD;
            end
          end
        end
        WRITE: state <= IDLE;
        READ_WAIT: begin
          // cnt==1 marks the last strobe cycle: sample data on this edge.
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            rdata_q <= bus.mem_rdata_i;
            state   <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
`ifdef MISALIGN_TRAP_EN
          err_q <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o  = (state == IDLE);
  assign bus.stall_o      = bus.req_valid_i && (state != IDLE);
  assign bus.resp_valid_o = (state == WRITE) || (state == RESP);
  assign bus.resp_rdata_o = rdata_q;
  assign bus.mem_write_o  = (state == WRITE);
  assign bus.mem_read_o   = (state == READ_WAIT);
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_wdata_o  = (state == WRITE) ? wdata_q : 32'd0;

`ifdef MISALIGN_TRAP_EN
  assign bus.err_o = err_q && (state == RESP);
`else
  assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_requester.sv
// tb_dmem_requester: directed stimulus with a response scoreboard.
// The stimulus process pushes the expected response of each request; a
// negedge monitor pops and compares whenever resp_valid_o is high and also
// checks the strobe invariants every cycle. A small 8-word memory model
// answers the requester's strobes.
module tb_dmem_requester;
  localparam int LAT = 3;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_requester_if bus();

  dmem_requester #(.MEM_LATENCY(LAT), .ADDR_WORDS(8)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [0:7];
  always @(posedge clk) begin
    if (bus.mem_write_o) mem[bus.mem_addr_o[2:0]] <= bus.mem_wdata_o;
  end
  assign bus.mem_rdata_i = bus.mem_read_o ? mem[bus.mem_addr_o[2:0]] : 32'h0;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard monitor and per-cycle invariants.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      check("strobe_overlap", 32'(bus.mem_write_o & bus.mem_read_o), 32'd0);
      if (!bus.mem_write_o) check("wdata_idle_zero", bus.mem_wdata_o, 32'd0);
      check("stall", 32'(bus.stall_o), 32'(bus.req_valid_i & ~bus.req_ready_o));
      if (bus.resp_valid_o) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_resp: resp_valid_o=1 with nothing outstanding at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("resp_err", 32'(bus.err_o), 32'(e.err));
          check("resp_rdata", bus.resp_rdata_o, e.data);
        end
      end else begin
        check("err_without_resp", 32'(bus.err_o), 32'd0);
      end
    end
  end

  task automatic wait_ready();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.req_ready_o) break;
    end
    check("accept_ready", 32'(bus.req_ready_o), 32'd1);
  endtask

  // Present a request and return 1 time unit after its accept edge; the
  // request stays on the bus until the caller changes or drops it.
  task automatic present(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic push, input logic exp_err, input logic [31:0] exp_data);
    exp_t e;
    bus.req_valid_i = 1'b1;
    bus.req_write_i = w;
    bus.req_addr_i  = a;
    bus.req_wdata_i = d;
    if (push) begin
      e.err  = exp_err;
      e.data = exp_data;
      sb.push_back(e);
    end
    wait_ready();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.req_valid_i = 1'b0;
    bus.req_write_i = 1'b0;
    bus.req_addr_i  = 32'h0;
    bus.req_wdata_i = 32'h0;
  endtask

  task automatic wait_quiet();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && bus.req_ready_o) break;
    end
    check("drain_outstanding", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_bus();

    // Reset state
    #2;
    check("rst_ready", 32'(bus.req_ready_o), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
    check("rst_mem_write", 32'(bus.mem_write_o), 32'd0);
    check("rst_mem_read", 32'(bus.mem_read_o), 32'd0);
    check("rst_mem_addr", bus.mem_addr_o, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
    check("rst_rdata", bus.resp_rdata_o, 32'd0);
    check("rst_err", 32'(bus.err_o), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Store 0x8 <- 0xDEADBEEF: single write cycle with response
    present(1'b1, 32'h8, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
    idle_bus();
    @(negedge clk);
    check("st_mem_write", 32'(bus.mem_write_o), 32'd1);
    check("st_mem_read", 32'(bus.mem_read_o), 32'd0);
    check("st_mem_addr", bus.mem_addr_o, 32'd2);
    check("st_mem_wdata", bus.mem_wdata_o, 32'hDEADBEEF);
    check("st_resp_valid", 32'(bus.resp_valid_o), 32'd1);
    @(negedge clk);
    check("st_ready_c2", 32'(bus.req_ready_o), 32'd1);
    check("st_resp_c2", 32'(bus.resp_valid_o), 32'd0);

    // Load 0x8: read strobe for LAT cycles, response in cycle LAT+1
    @(posedge clk);
    #1;
    present(1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
    idle_bus();
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      check($sformatf("ld_mem_read_c%0d", c), 32'(bus.mem_read_o), 32'(c <= LAT));
      check($sformatf("ld_resp_c%0d", c), 32'(bus.resp_valid_o), 32'(c == LAT + 1));
      if (c <= LAT) check($sformatf("ld_addr_c%0d", c), bus.mem_addr_o, 32'd2);
    end
    wait_quiet();

    // Back-to-back: second load held through the first
    @(posedge clk);
    #1;
    present(1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
    begin
      exp_t e2;
      e2.err  = 1'b0;
      e2.data = 32'hDEADBEEF;
      sb.push_back(e2);
    end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("b2b_mem_read_c%0d", c), 32'(bus.mem_read_o), 32'(c <= 3));
      check($sformatf("b2b_stall_c%0d", c), 32'(bus.stall_o), 32'(c <= 4));
      check($sformatf("b2b_ready_c%0d", c), 32'(bus.req_ready_o), 32'(c == 5));
    end
    @(posedge clk);
    #1;
    idle_bus();
    @(negedge clk);
    check("b2b_second_read_c6", 32'(bus.mem_read_o), 32'd1);
    wait_quiet();

    // Alternating store/load to 0x1C, request always pending
    @(posedge clk);
    #1;
    present(1'b1, 32'h1C, 32'h12345678, 1'b1, 1'b0, 32'hDEADBEEF);
    present(1'b0, 32'h1C, 32'h0,        1'b1, 1'b0, 32'h12345678);
    present(1'b1, 32'h1C, 32'hCAFEF00D, 1'b1, 1'b0, 32'h12345678);
    present(1'b0, 32'h1C, 32'h0,        1'b1, 1'b0, 32'hCAFEF00D);
    idle_bus();
    wait_quiet();

`ifdef MISALIGN_TRAP_EN
    // Misaligned and out-of-range loads trap without touching memory
    @(posedge clk);
    #1;
    present(1'b0, 32'h6, 32'h0, 1'b1, 1'b1, 32'hCAFEF00D);
    idle_bus();
    @(negedge clk);
    check("mis_mem_read", 32'(bus.mem_read_o), 32'd0);
    check("mis_mem_write", 32'(bus.mem_write_o), 32'd0);
    check("mis_err", 32'(bus.err_o), 32'd1);
    check("mis_resp", 32'(bus.resp_valid_o), 32'd1);
    wait_quiet();
    @(posedge clk);
    #1;
    present(1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 32'hCAFEF00D);
    idle_bus();
    @(negedge clk);
    check("oor_mem_read", 32'(bus.mem_read_o), 32'd0);
    check("oor_mem_write", 32'(bus.mem_write_o), 32'd0);
    check("oor_err", 32'(bus.err_o), 32'd1);
    check("oor_resp", 32'(bus.resp_valid_o), 32'd1);
    wait_quiet();
`else
    // Byte offset ignored: 0x1F addresses word 7
    @(posedge clk);
    #1;
    present(1'b0, 32'h1F, 32'h0, 1'b1, 1'b0, 32'hCAFEF00D);
    idle_bus();
    @(negedge clk);
    check("lsb_ignored_addr", bus.mem_addr_o, 32'd7);
    wait_quiet();
`endif

    // Reset during cycle 2 of a load aborts it without a response
    @(posedge clk);
    #1;
    present(1'b0, 32'h1C, 32'h0, 1'b0, 1'b0, 32'h0);
    idle_bus();
    @(negedge clk);
    check("abort_read_c1", 32'(bus.mem_read_o), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_read_dropped", 32'(bus.mem_read_o), 32'd0);
    check("abort_resp", 32'(bus.resp_valid_o), 32'd0);
    check("abort_ready", 32'(bus.req_ready_o), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("post_abort_resp_%0d", c), 32'(bus.resp_valid_o), 32'd0);
      check($sformatf("post_abort_read_%0d", c), 32'(bus.mem_read_o), 32'd0);
    end
    check("post_abort_ready", 32'(bus.req_ready_o), 32'd1);
    check("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dmem_requester.md
Name: dmem_requester

Overview:
- Initiator side of the data-memory port: the load/store requester in the CPU MEM stage.
- Accepts one load or store per handshake from the pipeline and drives the memory strobes MemWrite/MemRead, the word address and the write data.
- For loads, waits a configurable latency, captures read data and returns it to the pipeline with a one-cycle response pulse.
- Asserts stall while busy so the pipeline freezes.

Parameters:
- MEM_LATENCY, 1: cycles mem_read_o stays high before mem_rdata_i is sampled; legal range 1..15.
- ADDR_WORDS, 8: number of words in the attached memory; used for the range check.

Ports:
- clk_i input 1: clock, rising edge.
- rst_i input 1: reset, asynchronous, active-low.
- req_valid_i input 1: pipeline request valid.
- req_write_i input 1: 1 = store, 0 = load.
- req_addr_i input 32: byte address.
- req_wdata_i input 32: store data.
- req_ready_o output 1: requester can accept a request.
- stall_o output 1: req_valid_i && !req_ready_o.
- resp_valid_o output 1: one-cycle completion pulse (load data valid / store done).
- resp_rdata_o output 32: load data; holds its value until the next load completes.
- err_o output 1: one-cycle error pulse; driven only with MISALIGN_TRAP_EN, tied 0 otherwise.
- mem_write_o output 1: memory write strobe.
- mem_read_o output 1: memory read strobe.
- mem_addr_o output 32: word index = {2'b00, addr[31:2]}.
- mem_wdata_o output 32: memory write data.
- mem_rdata_i input 32: memory read data.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - All outputs 0 except req_ready_o=1.
  - Latency counter 0; captured address and data 0.
- States: IDLE, WRITE, READ_WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - Accept on the edge where req_valid_i=1. Register addr (word index) and wdata.
  - req_write_i=1 -> WRITE; req_write_i=0 -> READ_WAIT with counter loaded to MEM_LATENCY.
- WRITE (exactly 1 cycle):
  - mem_write_o=1; mem_addr_o and mem_wdata_o stable.
  - resp_valid_o=1 in the same cycle.
  - -> IDLE.
- READ_WAIT:
  - mem_read_o=1; mem_addr_o stable.
  - Counter decrements each cycle.
  - On the edge where counter==1, capture mem_rdata_i into resp_rdata_o and go to RESP.
  - mem_read_o is high for exactly MEM_LATENCY cycles.
- RESP (1 cycle): resp_valid_o=1, mem_read_o=0, -> IDLE.
- Latency from accept edge:
  - Store: resp in cycle 1.
  - Load: mem_read_o in cycles 1..L; resp in cycle L+1.
  - Next accept is possible at the end of the resp cycle.
- req_ready_o=0 in every state except IDLE; requests presented while busy are not accepted and raise stall_o.
- mem_write_o and mem_read_o are never high together, and are never high outside WRITE / READ_WAIT.
- mem_wdata_o is driven only in WRITE; it is 0 otherwise.
- Back-to-back: a request held on req_valid_i through RESP is accepted on the RESP->IDLE-following edge, i.e. the first IDLE cycle.
- Without MISALIGN_TRAP_EN, addr[1:0] is ignored.
- Reset asserted mid-transaction aborts it: strobes drop immediately and no resp pulse is generated.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - In IDLE, a request with addr[1:0]!=0 or word index >= ADDR_WORDS is accepted but issues no memory strobe.
  - Go to RESP with err_o=1 and resp_valid_o=1 for one cycle; resp_rdata_o is unchanged.
- Undefined: no check is made; err_o is constant 0.

Test Plan:
- Reset with rst_i=0 mid-load (MEM_LATENCY=3, cycle 2 of READ_WAIT) -> mem_read_o=0 immediately, ready=1 after release, no resp_valid_o.
- Store addr 0x8, data 0xDEADBEEF -> cycle 1: mem_write_o=1, mem_addr_o=2, mem_wdata_o=0xDEADBEEF, resp_valid_o=1; cycle 2 ready=1.
- Load addr 0x8, MEM_LATENCY=1, mem_rdata_i=0xDEADBEEF -> mem_read_o high 1 cycle, resp_valid_o in cycle 2, resp_rdata_o=0xDEADBEEF.
- MEM_LATENCY=3 load with req_valid_i held for a second load -> mem_read_o high cycles 1–3, stall_o=1 cycles 1–4, second request accepted cycle 5.
- Alternating store/load to addr 0x1C with no gaps -> strobes never overlap, load returns stored value 0x12345678.
- With MISALIGN_TRAP_EN: load addr 0x6 -> no mem strobe, err_o=1 and resp_valid_o=1 in cycle 1. Load addr 0x20 (index 8, ADDR_WORDS=8) -> same result.
